// File: rtl/mc_mem_pkg.sv
// mc_mem_pkg
// Shared definitions for the multicycle memory responder slice:
//   - mc_state_e : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_W     : memory word width
//   - OP_RD/OP_WR: latched operation encoding
package mc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mc_state_e;

    localparam int WORD_W = 32;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mc_mem_responder_if.sv
// mc_mem_responder_if
// Memory strobe bus between the multicycle sequencer (master) and the
// memory responder (slave).
//   Mread, Mwrite : request strobes (master -> slave)
//   addr, wdata   : byte address and write data (master -> slave)
//   rdata         : last completed read data (slave -> master)
//   ready         : one-cycle completion pulse (slave -> master)
//   busy          : request outstanding (slave -> master)
//   err           : one-cycle error pulse (slave -> master)
//
// Handshake: a request is offered by raising exactly one strobe while the
// responder is idle; it is taken at the first clock edge that sees it. The
// master keeps the strobe up until it observes ready and drops it then;
// strobes seen while busy are ignored, and a strobe still high on the idle
// cycle after ready starts a new request.
import mc_mem_pkg::*;

interface mc_mem_responder_if;
    logic              Mread;
    logic              Mwrite;
    logic [31:0]       addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output Mread, Mwrite, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  Mread, Mwrite, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/mc_mem_array.sv
// mc_mem_array
// Single-port synchronous RAM, 2**ADDR_W words of WORD_W bits.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (read register only; the
//           storage array itself is not reset)
//   we    : write enable, writes wdata to mem[idx]
//   re    : read enable, loads mem[idx] into the read register
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, holds until the next read
import mc_mem_pkg::*;

module mc_mem_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[idx];
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/mc_mem_responder.sv
// mc_mem_responder
// Unified instruction/data memory answering the multicycle sequencer's
// Mread/Mwrite strobes. A request is latched in IDLE, waits WAIT_CYCLES
// cycles, then completes with a one-cycle ready pulse in RESP.
//
// Parameters:
//   ADDR_W      : word-address width (depth 2**ADDR_W words)
//   WAIT_CYCLES : wait states between acceptance and response (0..7)
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset; aborts any pending request
//   bus       : slave side of mc_mem_responder_if
//   state_dbg : current FSM state
//
// Optional feature (macro MEM_ALIGN_CHECK_EN): a request with
// addr[1:0] != 0 still runs the full wait sequence, but completes with
// ready and err together and performs no access.
import mc_mem_pkg::*;

module mc_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    mc_mem_responder_if.slave         bus,
    output mc_state_e                 state_dbg
);

    mc_state_e         state;
    logic [2:0]        cnt;
    logic              lat_op;
    logic [ADDR_W-1:0] lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic              ready_q;
    logic              err_q;

    logic              one_strobe;
    logic              both_strobes;
    logic              accept;
    logic              go_resp;
    logic              op_now;
    logic [ADDR_W-1:0] idx_now;
    logic [WORD_W-1:0] wdata_now;
    logic              mis_now;
    logic              arr_we;
    logic              arr_re;

    assign one_strobe   = bus.Mread ^ bus.Mwrite;
    assign both_strobes = bus.Mread & bus.Mwrite;
    assign accept       = (state == IDLE) && one_strobe;

    // The edge entering RESP is where the array access happens. With zero
    // wait states that edge is the acceptance edge itself, so the access
    // fields come straight from the bus in IDLE and from the latches after.
    assign go_resp   = (accept && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == 3'd1));
    assign op_now    = (state == IDLE) ? (bus.Mwrite ? OP_WR : OP_RD) : lat_op;
    assign idx_now   = (state == IDLE) ? bus.addr[ADDR_W+1:2] : lat_idx;
    assign wdata_now = (state == IDLE) ? bus.wdata : lat_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic lat_mis;
    logic unused_addr_bits;
    assign mis_now = (state == IDLE) ? (bus.addr[1:0] != 2'b00) : lat_mis;
    assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];
`else
    logic unused_addr_bits;
    assign mis_now = 1'b0;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

    // Gated by reset so a strobe held during reset can never reach the array.
    assign arr_we = ~reset & go_resp & (op_now == OP_WR) & ~mis_now;
    assign arr_re = ~reset & go_resp & (op_now == OP_RD) & ~mis_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            lat_op    <= OP_RD;
            lat_idx   <= '0;
            lat_wdata <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            lat_mis   <= 1'b0;
`endif
        end else begin
            ready_q <= go_resp;
            err_q   <= ((state == IDLE) && both_strobes) || (go_resp && mis_now);
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_op    <= op_now;
                        lat_idx   <= bus.addr[ADDR_W+1:2];
                        lat_wdata <= bus.wdata;
`ifdef MEM_ALIGN_CHECK_EN
                        lat_mis   <= (bus.addr[1:0] != 2'b00);
`endif
                        cnt       <= 3'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mc_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_now),
        .wdata (wdata_now),
        .rdata (bus.rdata)
    );

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder
// Three responders with WAIT_CYCLES = 1, 0 and 3 share one clock and reset.
// A timestamp model predicts ready/busy/err/state/rdata for each instance
// from the acceptance edge number; directed sequences add literal checks.
import mc_mem_pkg::*;

module tb_mc_mem_responder;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        mread   [3];
    logic        mwrite  [3];
    logic [31:0] addr_i  [3];
    logic [31:0] wdata_i [3];
    logic [31:0] rdata_o [3];
    logic        ready_o [3];
    logic        busy_o  [3];
    logic        err_o   [3];
    logic [1:0]  st_o    [3];

    int tests = 0;
    int fails = 0;

    function automatic int wc_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : inst
            localparam int W = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
            mc_mem_responder_if bus ();
            mc_state_e st;
            assign bus.Mread   = mread[gi];
            assign bus.Mwrite  = mwrite[gi];
            assign bus.addr    = addr_i[gi];
            assign bus.wdata   = wdata_i[gi];
            assign rdata_o[gi] = bus.rdata;
            assign ready_o[gi] = bus.ready;
            assign busy_o[gi]  = bus.busy;
            assign err_o[gi]   = bus.err;
            assign st_o[gi]    = st;
            mc_mem_responder #(
                .ADDR_W      (10),
                .WAIT_CYCLES (W)
            ) dut (
                .clk       (clk),
                .reset     (reset),
                .bus       (bus),
                .state_dbg (st)
            );
        end
    endgenerate

    // Clock
    initial forever #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Edge e is the e-th rising edge out of reset. A request accepted at edge A
    // keeps the block busy after edges A..A+WC, with ready after edge A+WC.
    bit          m_active [3];
    int          m_acc    [3];
    bit          m_op     [3];
    int          m_idx    [3];
    logic [31:0] m_wd     [3];
    bit          m_mis    [3];
    logic [31:0] m_rdata  [3];
    bit          m_known  [3];
    bit          e_ready  [3];
    bit          e_busy   [3];
    bit          e_err    [3];
    int          ecnt = 0;
    logic [31:0] mmem [int];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_active[i] = 1'b0;
                m_rdata[i]  = 32'h0;
                m_known[i]  = 1'b1;
                e_ready[i]  = 1'b0;
                e_busy[i]   = 1'b0;
                e_err[i]    = 1'b0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < 3; i++) begin
                int w;
                int key;
                bit was_busy;
                bit blocked;
                w = wc_of(i);
                was_busy = m_active[i] && (ecnt - 1 >= m_acc[i]) && (ecnt - 1 <= m_acc[i] + w);
                e_err[i] = 1'b0;
                if (!was_busy) begin
                    if (mread[i] && mwrite[i]) begin
                        e_err[i] = 1'b1;
                    end else if (mread[i] || mwrite[i]) begin
                        m_active[i] = 1'b1;
                        m_acc[i]    = ecnt;
                        m_op[i]     = mwrite[i];
                        m_idx[i]    = int'(addr_i[i][11:2]);
                        m_wd[i]     = wdata_i[i];
                        m_mis[i]    = (addr_i[i][1:0] != 2'b00);
                    end
                end
                e_busy[i]  = m_active[i] && (ecnt >= m_acc[i]) && (ecnt <= m_acc[i] + w);
                e_ready[i] = m_active[i] && (ecnt == m_acc[i] + w);
                if (e_ready[i]) begin
                    key = i * 65536 + m_idx[i];
                    blocked = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    blocked = m_mis[i];
`endif
                    if (blocked) begin
                        e_err[i] = 1'b1;
                    end else if (m_op[i]) begin
                        mmem[key] = m_wd[i];
                    end else if (mmem.exists(key)) begin
                        m_rdata[i] = mmem[key];
                        m_known[i] = 1'b1;
                    end else begin
                        m_known[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("i%0d ready", i), 32'(ready_o[i]), 32'(e_ready[i]));
            check($sformatf("i%0d busy", i), 32'(busy_o[i]), 32'(e_busy[i]));
            check($sformatf("i%0d err", i), 32'(err_o[i]), 32'(e_err[i]));
            check($sformatf("i%0d state", i), 32'(st_o[i]),
                  e_busy[i] ? (e_ready[i] ? 32'd2 : 32'd1) : 32'd0);
            if (m_known[i]) begin
                check($sformatf("i%0d rdata", i), rdata_o[i], m_rdata[i]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises one strobe, holds it until ready (bounded), then drops it.
    // lat counts rising edges from raising the strobe to seeing ready.
    task automatic access(input int g, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit chg,
                          output int lat, output logic [31:0] rd, output bit er);
        bit ok;
        mread[g]   = !wr;
        mwrite[g]  = wr;
        addr_i[g]  = a;
        wdata_i[g] = d;
        lat = 0;
        ok  = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (chg && lat == 1) addr_i[g] = a ^ 32'h0000_0100;
            if (ready_o[g]) begin
                ok = 1'b1;
                rd = rdata_o[g];
                er = err_o[g];
                break;
            end
        end
        mread[g]  = 1'b0;
        mwrite[g] = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL i%0d timeout: got no ready expected ready within 20 cycles", g);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          lat;
        logic [31:0] rd;
        bit          er;
        for (int i = 0; i < 3; i++) begin
            mread[i] = 1'b0; mwrite[i] = 1'b0; addr_i[i] = 32'h0; wdata_i[i] = 32'h0;
            m_active[i] = 1'b0; m_acc[i] = 0; m_op[i] = 1'b0; m_idx[i] = 0;
            m_wd[i] = 32'h0; m_mis[i] = 1'b0; m_rdata[i] = 32'h0; m_known[i] = 1'b1;
            e_ready[i] = 1'b0; e_busy[i] = 1'b0; e_err[i] = 1'b0;
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset rdata", rdata_o[i], 32'h0);
            check("reset ready", 32'(ready_o[i]), 32'd0);
            check("reset busy", 32'(busy_o[i]), 32'd0);
            check("reset err", 32'(err_o[i]), 32'd0);
        end
        reset = 1'b0;
        idle(1);

        // WAIT_CYCLES=1: write then read 0x10
        access(0, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, lat, rd, er);
        check("wc1 write latency", 32'(lat), 32'd2);
        idle(1);
        access(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        check("wc1 read latency", 32'(lat), 32'd2);
        check("wc1 read data", rd, 32'hCAFEF00D);

        // WAIT_CYCLES=0: preload, then back-to-back reads
        idle(1);
        access(1, 1'b1, 32'h0, 32'h00000AAA, 1'b0, lat, rd, er);
        access(1, 1'b1, 32'h4, 32'h00000BBB, 1'b0, lat, rd, er);
        idle(1);
        access(1, 1'b0, 32'h0, 32'h0, 1'b0, lat, rd, er);
        check("wc0 first read latency", 32'(lat), 32'd1);
        check("wc0 first read data", rd, 32'h00000AAA);
        access(1, 1'b0, 32'h4, 32'h0, 1'b0, lat, rd, er);
        check("wc0 back-to-back latency", 32'(lat), 32'd2);
        check("wc0 second read data", rd, 32'h00000BBB);

        // Address wrap: 0x1010 aliases word 4 (byte 0x10) with ADDR_W=10
        idle(1);
        access(1, 1'b1, 32'h1010, 32'h0BADBEEF, 1'b0, lat, rd, er);
        idle(1);
        access(1, 1'b0, 32'h10, 32'h0, 1'b0, lat, rd, er);
        check("wrap read data", rd, 32'h0BADBEEF);

        // Both strobes: err pulse, no access
        idle(1);
        access(0, 1'b1, 32'h20, 32'h11112222, 1'b0, lat, rd, er);
        idle(1);
        mread[0] = 1'b1; mwrite[0] = 1'b1; addr_i[0] = 32'h20; wdata_i[0] = 32'hDEADDEAD;
        @(posedge clk);
        #1;
        check("both err", 32'(err_o[0]), 32'd1);
        check("both ready", 32'(ready_o[0]), 32'd0);
        check("both busy", 32'(busy_o[0]), 32'd0);
        mread[0] = 1'b0; mwrite[0] = 1'b0;
        @(posedge clk);
        #1;
        check("both err one cycle", 32'(err_o[0]), 32'd0);
        access(0, 1'b0, 32'h20, 32'h0, 1'b0, lat, rd, er);
        check("both old data", rd, 32'h11112222);

        // Reset during WAIT aborts a write
        idle(1);
        access(0, 1'b1, 32'h30, 32'h00003030, 1'b0, lat, rd, er);
        idle(1);
        mwrite[0] = 1'b1; addr_i[0] = 32'h30; wdata_i[0] = 32'h12345678;
        @(posedge clk);
        #1;
        check("abort accepted busy", 32'(busy_o[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("abort ready", 32'(ready_o[0]), 32'd0);
        check("abort busy", 32'(busy_o[0]), 32'd0);
        check("abort err", 32'(err_o[0]), 32'd0);
        check("abort state", 32'(st_o[0]), 32'd0);
        mwrite[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        access(0, 1'b0, 32'h30, 32'h0, 1'b0, lat, rd, er);
        check("abort old data", rd, 32'h00003030);

        // WAIT_CYCLES=3: address change in WAIT is ignored
        idle(1);
        access(2, 1'b1, 32'h50, 32'h50500001, 1'b0, lat, rd, er);
        access(2, 1'b1, 32'h150, 32'h01500002, 1'b0, lat, rd, er);
        idle(1);
        access(2, 1'b0, 32'h50, 32'h0, 1'b1, lat, rd, er);
        check("wc3 latency", 32'(lat), 32'd4);
        check("wc3 latched addr data", rd, 32'h50500001);

        // Misaligned write to 0x41
        idle(1);
        access(0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, lat, rd, er);
        idle(1);
        access(0, 1'b1, 32'h41, 32'hFFFFFFFF, 1'b0, lat, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign err with ready", 32'(er), 32'd1);
`else
        check("misalign err with ready", 32'(er), 32'd0);
`endif
        idle(1);
        access(0, 1'b0, 32'h40, 32'h0, 1'b0, lat, rd, er);
`ifdef MEM_ALIGN_CHECK_EN
        check("misalign word 0x40", rd, 32'hA5A5A5A5);
`else
        check("misalign word 0x40", rd, 32'hFFFFFFFF);
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
